// File: rtl/stream_delay_pkg.sv
// Shared types and constants for the buffered stream delayer.
// The delay-mode enum selects where each accepted beat gets its delay value.
package stream_delay_pkg;

    typedef enum logic [1:0] {
        DelayFixed   = 2'd0,
        DelayRandom  = 2'd1,
        DelayRuntime = 2'd2
    } delay_mode_e;

    localparam logic [15:0] LfsrSeed = 16'hACE1;

endpackage

// File: rtl/delay_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used as the random delay source.
// Advances one step per cycle while en_i is high; otherwise holds.
module delay_lfsr
    import stream_delay_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] q_o
);

    localparam logic [15:0] TapMask = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TapMask : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/stream_delay_buffered.sv
// In-order buffered stream delayer: up to Depth beats queued, each released once
// its own delay (fixed, LFSR-random or sampled from delay_i) has counted down.
module stream_delay_buffered
    import stream_delay_pkg::*;
#(
    parameter int unsigned PayloadWidth = 32,
    parameter int unsigned Depth        = 4,
    parameter int unsigned DelayWidth   = 4,
    parameter delay_mode_e Mode         = DelayFixed,
    parameter int unsigned FixedDelay   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [DelayWidth-1:0]        delay_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [PayloadWidth-1:0]      payload_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [PayloadWidth-1:0]      payload_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned UsageWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [UsageWidth-1:0] FullCount = UsageWidth'(Depth);

    logic [PayloadWidth-1:0] payload_q [Depth];
    logic [DelayWidth-1:0]   cnt_q     [Depth];
    logic [Depth-1:0]        occupied_q;
    logic [Depth-1:0]        occupied_d;
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [UsageWidth-1:0]   usage_q;

    logic                    full;
    logic                    empty;
    logic                    head_due;
    logic                    push;
    logic                    pop;
    logic [DelayWidth-1:0]   delay_sel;
    logic [15:0]             lfsr_q;
    logic                    lfsr_unused;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full     = (usage_q == FullCount);
    assign empty    = (usage_q == '0);
    assign head_due = (cnt_q[rd_ptr_q] == '0);

    // Handshake: a beat moves on a side only in a cycle where that side's valid and
    // ready are both high. ready_o is a function of fill level and flush only (never
    // ready_i), and valid_o is a function of stored state and flush only (never valid_i),
    // so a raised valid_o with its payload stays put until the consumer takes it.
    assign ready_o   = !full && !flush_i;
    assign valid_o   = !empty && head_due && !flush_i;
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;
    assign payload_o = valid_o ? payload_q[rd_ptr_q] : '0;
    assign usage_o   = usage_q;

    delay_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (push),
        .q_o    (lfsr_q)
    );

    // Only the low DelayWidth bits feed the delay; the rest is deliberately dropped.
    assign lfsr_unused = ^lfsr_q;

    always_comb begin
        delay_sel = DelayWidth'(FixedDelay);
        case (Mode)
            DelayRandom:  delay_sel = lfsr_q[DelayWidth-1:0];
            DelayRuntime: delay_sel = delay_i;
            default:      delay_sel = DelayWidth'(FixedDelay);
        endcase
    end

    always_comb begin
        occupied_d = occupied_q;
        if (pop) begin
            occupied_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            occupied_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            occupied_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            occupied_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   usage_q <= usage_q + UsageWidth'(1);
                2'b01:   usage_q <= usage_q - UsageWidth'(1);
                default: usage_q <= usage_q;
            endcase
            occupied_q <= occupied_d;
        end
    end

    // Every queued beat counts down in parallel; a freshly written entry starts next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                payload_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (push && (wr_ptr_q == PtrWidth'(i))) begin
                    payload_q[i] <= payload_i;
                    cnt_q[i]     <= delay_sel;
                end else if (occupied_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_delay_buffered.sv
// Bench for stream_delay_buffered: fixed, runtime and random-delay instances driven
// from shared inputs, checked against a queue-based release-time model.
module tb_stream_delay_buffered;
    import stream_delay_pkg::*;

    localparam int PW = 32;
    localparam int DP = 4;
    localparam int DW = 4;
    localparam int UW = $clog2(DP + 1);
    localparam int SelFix = 0;
    localparam int SelRt  = 1;
    localparam int SelRnd = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_ni;
    logic          flush_i;
    logic          valid_i;
    logic          ready_i;
    logic [DW-1:0] delay_i;
    logic [PW-1:0] payload_i;

    logic f_ready, f_valid, r_ready, r_valid, x_ready, x_valid;
    logic [PW-1:0] f_pay, r_pay, x_pay;
    logic [UW-1:0] f_usage, r_usage, x_usage;

    stream_delay_buffered #(.PayloadWidth(PW), .Depth(DP), .DelayWidth(DW),
                            .Mode(DelayFixed), .FixedDelay(3)) u_fix (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .delay_i(delay_i),
        .valid_i(valid_i), .ready_o(f_ready), .payload_i(payload_i),
        .valid_o(f_valid), .ready_i(ready_i), .payload_o(f_pay), .usage_o(f_usage));

    stream_delay_buffered #(.PayloadWidth(PW), .Depth(DP), .DelayWidth(DW),
                            .Mode(DelayRuntime), .FixedDelay(0)) u_rt (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .delay_i(delay_i),
        .valid_i(valid_i), .ready_o(r_ready), .payload_i(payload_i),
        .valid_o(r_valid), .ready_i(ready_i), .payload_o(r_pay), .usage_o(r_usage));

    stream_delay_buffered #(.PayloadWidth(PW), .Depth(DP), .DelayWidth(DW),
                            .Mode(DelayRandom), .FixedDelay(0)) u_rnd (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .delay_i(delay_i),
        .valid_i(valid_i), .ready_o(x_ready), .payload_i(payload_i),
        .valid_o(x_valid), .ready_i(ready_i), .payload_o(x_pay), .usage_o(x_usage));

    int sel = SelFix;
    logic          o_ready, o_valid;
    logic [PW-1:0] o_pay;
    logic [UW-1:0] o_usage;

    always_comb begin
        o_ready = f_ready;
        o_valid = f_valid;
        o_pay   = f_pay;
        o_usage = f_usage;
        if (sel == SelRt) begin
            o_ready = r_ready;
            o_valid = r_valid;
            o_pay   = r_pay;
            o_usage = r_usage;
        end else if (sel == SelRnd) begin
            o_ready = x_ready;
            o_valid = x_valid;
            o_pay   = x_pay;
            o_usage = x_usage;
        end
    end

    // Reference model: queued beats with the earliest cycle each may be released.
    typedef struct {
        logic [PW-1:0] pay;
        int            rel;
    } beat_t;

    beat_t       mq[$];
    int          cyc;
    int          n_acc;
    logic [15:0] m_lfsr;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s sel=%0d t=%0d: got 0x%0h, expected 0x%0h", name, sel, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input int s);
        sel       = s;
        rst_ni    = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        delay_i   = '0;
        payload_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        mq.delete();
        cyc    = 0;
        n_acc  = 0;
        m_lfsr = 16'hACE1;
        @(negedge clk_i);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_usage", o_usage, 0);
        check("rst_payload", o_pay, 0);
        @(posedge clk_i);
        #1;
    endtask

    // One clock cycle: compare outputs to the model, then advance model with the edge.
    task automatic step();
        logic ev, er, push, pop;
        int d;
        @(negedge clk_i);
        ev = (mq.size() > 0) && (cyc >= mq[0].rel) && !flush_i;
        er = (mq.size() < DP) && !flush_i;
        check("valid_o", o_valid, ev);
        check("ready_o", o_ready, er);
        check("usage_o", o_usage, mq.size());
        if (ev) check("payload_o", o_pay, mq[0].pay);
        push = valid_i && er;
        pop  = ev && ready_i;
        case (sel)
            SelFix:  d = 3;
            SelRt:   d = int'(delay_i);
            default: d = int'(m_lfsr[DW-1:0]);
        endcase
        @(posedge clk_i);
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pay: payload_i, rel: cyc + 1 + d});
                m_lfsr = lfsr_next(m_lfsr);
                n_acc++;
            end
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic          vi;
        logic [PW-1:0] pi;
        logic          ri;
        logic          ev;
        logic [PW-1:0] ep;
        logic [UW-1:0] eu;
        logic          er;
    } vec_t;

    vec_t tbl[13];
    bit   did_rst;

    initial begin
        // Fixed D=3: beat 0xA5 at t=0 shows at t=4; beat 0x5A at t=5 waits on ready_i.
        tbl[0]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 32'h0,  3'd0, 1'b1};
        tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5, 3'd1, 1'b1};
        tbl[5]  = '{1'b1, 32'h5A, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  3'd1, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h5A, 3'd1, 1'b1};
        tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h5A, 3'd1, 1'b1};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h5A, 3'd1, 1'b1};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  3'd0, 1'b1};

        do_reset(SelFix);
        for (int i = 0; i < 13; i++) begin
            cyc       = i;
            valid_i   = tbl[i].vi;
            payload_i = tbl[i].pi;
            ready_i   = tbl[i].ri;
            @(negedge clk_i);
            check("tbl_valid", f_valid, tbl[i].ev);
            check("tbl_usage", f_usage, tbl[i].eu);
            check("tbl_ready", f_ready, tbl[i].er);
            if (tbl[i].ev) check("tbl_payload", f_pay, tbl[i].ep);
            @(posedge clk_i);
            #1;
        end

        // Runtime delays 5,0,0 back to back: released in order at t=6,7,8.
        do_reset(SelRt);
        ready_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            valid_i   = (t < 3);
            delay_i   = (t == 0) ? 4'd5 : 4'd0;
            payload_i = 32'h100 + t;
            check("rt_valid", o_valid, (t >= 6 && t <= 8));
            if (t >= 6 && t <= 8) check("rt_payload", o_pay, 32'h100 + t - 6);
            step();
        end

        // Fill to Depth with ready_i low, hold the head, then pop/push together.
        do_reset(SelRt);
        delay_i = '0;
        valid_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            payload_i = 32'h200 + ((t < 4) ? t : 4);
            check("fill_ready", o_ready, (t < 4));
            step();
        end
        check("fill_usage", o_usage, 4);
        for (int t = 0; t < 10; t++) begin
            check("hold_payload", o_pay, 32'h200);
            check("hold_valid", o_valid, 1'b1);
            step();
        end
        ready_i = 1'b1;
        check("full_pop_ready", o_ready, 1'b0);
        step();
        check("after_pop_usage", o_usage, 3);
        step();
        check("pushpop_usage", o_usage, 3);
        payload_i = 32'h205;
        step();
        valid_i = 1'b0;
        repeat (6) step();
        check("drain_usage", o_usage, 0);

        // Flush with three beats queued (D=2): head would be due in the flush cycle.
        do_reset(SelRt);
        delay_i = 4'd2;
        valid_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            payload_i = 32'h300 + t;
            step();
        end
        payload_i = 32'h3FF;
        ready_i   = 1'b1;
        flush_i   = 1'b1;
        #1;
        check("flush_ready", o_ready, 1'b0);
        check("flush_valid", o_valid, 1'b0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check("post_flush_usage", o_usage, 0);
        check("post_flush_valid", o_valid, 1'b0);
        repeat (3) step();

        // Random delays, random traffic, async reset midway, 1000 accepted beats.
        do_reset(SelRnd);
        did_rst = 1'b0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            valid_i   = ($urandom_range(0, 9) < 7);
            ready_i   = ($urandom_range(0, 9) < 6);
            flush_i   = ($urandom_range(0, 299) == 0);
            payload_i = $urandom;
            delay_i   = DW'($urandom);
            if (!did_rst && n_acc >= 500) begin
                did_rst = 1'b1;
                valid_i = 1'b0;
                flush_i = 1'b0;
                #2 rst_ni = 1'b0;
                #1;
                check("async_rst_usage", o_usage, 0);
                check("async_rst_valid", o_valid, 1'b0);
                check("async_rst_ready", o_ready, 1'b1);
                @(posedge clk_i);
                #1 rst_ni = 1'b1;
                mq.delete();
                m_lfsr = 16'hACE1;
            end
            step();
        end
        check("rnd_accept_count", (n_acc >= 1000), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
